// File: rtl/fsm_tx_pkg.sv
// State codes shared between the serial transmitter and the receive-side checker,
// plus a small sizing helper for the phase counter.
package fsm_tx_pkg;

   typedef enum logic [2:0] {
      TX_IDLE = 3'd0,
      TX_PRE  = 3'd1,
      TX_SEP  = 3'd2,
      TX_DATA = 3'd3,
      TX_GAP  = 3'd4
   } tx_state_t;

   // Largest of three phase lengths; sizes the shared down-counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/fsm_serial_tx.sv
// Serial frame transmitter: preamble of 1s, a 0 separator, payload MSB-first,
// then a trailing 0 gap. One frame in flight; words offered while busy are dropped.
module fsm_serial_tx
   import fsm_tx_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PRE_LEN = 2,
   parameter int GAP_LEN = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              wo,
   output logic              busy,
   output logic              done
);

   localparam int MAX_LEN = max3(PRE_LEN, DATA_W, GAP_LEN);
   localparam int CNT_W   = $clog2(MAX_LEN) + 1;

   localparam logic [CNT_W-1:0] PRE_M1  = CNT_W'(PRE_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_M1 = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_LEN - 1);

   tx_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;

   // Frame sequencer: state, phase counter, shift register and the registered line.
   // wo is loaded with the value belonging to the state being entered, so the line
   // changes on the same edge as the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= TX_IDLE;
         cnt   <= '0;
         shreg <= '0;
         wo    <= 1'b0;
      end else begin
         case (state)
            TX_IDLE: begin
               if (load_valid) begin
                  state <= TX_PRE;
                  cnt   <= PRE_M1;
                  shreg <= load_data;
                  wo    <= 1'b1;
               end else begin
                  wo    <= 1'b0;
               end
            end
            TX_PRE: begin
               if (cnt == '0) begin
                  state <= TX_SEP;
                  wo    <= 1'b0;
               end else begin
                  cnt   <= cnt - 1'b1;
                  wo    <= 1'b1;
               end
            end
            TX_SEP: begin
               state <= TX_DATA;
               cnt   <= DATA_M1;
               wo    <= shreg[DATA_W-1];
               shreg <= shreg << 1;
            end
            TX_DATA: begin
               if (cnt == '0) begin
                  state <= TX_GAP;
                  cnt   <= GAP_M1;
                  wo    <= 1'b0;
               end else begin
                  cnt   <= cnt - 1'b1;
                  wo    <= shreg[DATA_W-1];
                  shreg <= shreg << 1;
               end
            end
            TX_GAP: begin
               wo <= 1'b0;
               if (cnt == '0) begin
                  state <= TX_IDLE;
               end else begin
                  cnt   <= cnt - 1'b1;
               end
            end
            default: begin
               state <= TX_IDLE;
               cnt   <= '0;
               wo    <= 1'b0;
            end
         endcase
      end
   end

   // Status outputs decoded purely from registered state, so they cannot glitch on inputs.
   always_comb begin
      load_ready = (state == TX_IDLE);
      busy       = (state != TX_IDLE);
      done       = (state == TX_GAP) && (cnt == '0);
   end

endmodule

// File: tb/tb_fsm_serial_tx.sv
// Directed bench for fsm_serial_tx: reset, frame shapes, back-to-back loads,
// ignored loads while busy, async reset mid-frame and a minimum-size instance.
module tb_fsm_serial_tx;

   logic       clk;
   logic       reset;
   logic       lv;
   logic [7:0] ld;
   logic       lr, wo, busy, done;
   logic       lv1;
   logic [0:0] ld1;
   logic       lr1, wo1, busy1, done1;

   int errors = 0;
   int checks = 0;

   logic [12:0] exp_a5 = 13'b1101010010100;
   logic [12:0] exp_ff = 13'b1101111111100;
   logic [12:0] exp_00 = 13'b1100000000000;
   logic [12:0] exp_3c = 13'b1100011110000;
   logic [3:0]  exp_w1 = 4'b1010;

   fsm_serial_tx #(.DATA_W(8), .PRE_LEN(2), .GAP_LEN(2)) dut (
      .clk(clk), .reset(reset), .load_valid(lv), .load_data(ld),
      .load_ready(lr), .wo(wo), .busy(busy), .done(done)
   );

   fsm_serial_tx #(.DATA_W(1), .PRE_LEN(1), .GAP_LEN(1)) dut1 (
      .clk(clk), .reset(reset), .load_valid(lv1), .load_data(ld1),
      .load_ready(lr1), .wo(wo1), .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_ready"}, lr, 1'b1);
      chk({tag, "_wo"}, wo, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
   endtask

   // Called one step after the accepting edge; walks all 13 frame cycles.
   task automatic run_frame(input logic [12:0] exp, input string tag, input int pulse_at);
      for (int i = 0; i < 13; i++) begin
         chk($sformatf("%s_wo%0d", tag, i), wo, exp[12-i]);
         chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
         chk($sformatf("%s_done%0d", tag, i), done, (i == 12));
         chk($sformatf("%s_ready%0d", tag, i), lr, 1'b0);
         if (pulse_at >= 0) begin
            lv = (i == pulse_at);
            if (i == pulse_at) ld = 8'h3C;
         end
         tick();
      end
      chk_idle({tag, "_end"});
   endtask

   initial begin
      reset = 1'b0;
      lv = 1'b0; ld = 8'h00;
      lv1 = 1'b0; ld1 = 1'b0;

      // reset held three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle($sformatf("rst%0d", i));
         chk("rst_w1_busy", busy1, 1'b0);
         chk("rst_w1_ready", lr1, 1'b1);
      end
      reset = 1'b1;
      tick();
      chk_idle("post_rst");

      // single frame A5
      lv = 1'b1; ld = 8'hA5;
      tick();
      lv = 1'b0;
      run_frame(exp_a5, "a5", -1);

      // held valid: FF then 00 back-to-back
      lv = 1'b1; ld = 8'hFF;
      tick();
      ld = 8'h00;
      run_frame(exp_ff, "ff", -1);
      tick();
      lv = 1'b0;
      run_frame(exp_00, "b2b", -1);

      // load pulse during a frame is dropped
      lv = 1'b1; ld = 8'hA5;
      tick();
      lv = 1'b0;
      run_frame(exp_a5, "ign", 4);
      lv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle($sformatf("ign_after%0d", i));
      end

      // async reset in the middle of the payload
      lv = 1'b1; ld = 8'hA5;
      tick();
      lv = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("ar_wo%0d", i), wo, exp_a5[12-i]);
         tick();
      end
      chk("ar_busy_before", busy, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk_idle("ar_async");
      tick();
      reset = 1'b1;
      chk_idle("ar_release");
      lv = 1'b1; ld = 8'h3C;
      tick();
      lv = 1'b0;
      run_frame(exp_3c, "3c", -1);

      // minimum parameter instance
      lv1 = 1'b1; ld1 = 1'b1;
      tick();
      lv1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("w1_wo%0d", i), wo1, exp_w1[3-i]);
         chk($sformatf("w1_busy%0d", i), busy1, 1'b1);
         chk($sformatf("w1_done%0d", i), done1, (i == 3));
         tick();
      end
      chk("w1_end_busy", busy1, 1'b0);
      chk("w1_end_ready", lr1, 1'b1);
      chk("w1_end_wo", wo1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
